pipeline_stall_controller: RTL
==============================

Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It replaces the purely combinational load-use check with a controller that also schedules the multi-cycle mult/div unit and applies taken-branch flushes. It drives the PC write enable, the IF/ID write enable, the ID/EX bubble mux select, the IF/ID flush, and the mult/div start signal. It also keeps a stall-cycle performance counter.

Parameters:
MULDIV_LAT, 8, number of cycles the mult/div unit is busy after start (legal range 1..15)
CNT_W, 4, width of the internal busy down-counter (must hold MULDIV_LAT)
PERF_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_RegisterRt  in  5  load destination register
IF_ID_RegisterRs  in  5  rs of the instruction in ID
IF_ID_RegisterRt  in  5  rt of the instruction in ID
IF_ID_UsesRt  in  1  instruction in ID reads rt
ID_MulDiv  in  1  instruction in ID is mult/multu/div/divu
ID_ReadsHiLo  in  1  instruction in ID is mfhi/mflo
branch_taken  in  1  branch resolved taken in ID this cycle
PCWrite  out  1  1 = PC updates
IF_ID_Write  out  1  1 = IF/ID register loads
stall_mux  out  1  0 = inject bubble (zero control) into ID/EX
IF_ID_Flush  out  1  1 = clear IF/ID on next edge
muldiv_start  out  1  one-cycle start pulse to the mult/div unit
muldiv_busy  out  1  mult/div unit is busy
stall_cycles  out  PERF_W  saturating count of cycles with PCWrite=0

Behaviour:
- States: RUN, MD_BUSY. Registers: state, busy down-counter cnt[CNT_W], stall_cycles.
- Reset (async, rst_n=0): state=RUN, cnt=0, stall_cycles=0. While in reset: PCWrite=1, IF_ID_Write=1, stall_mux=1, IF_ID_Flush=0, muldiv_start=0, muldiv_busy=0.
- Reset mid-operation abandons MD_BUSY; muldiv_busy drops immediately.
- load_use (combinational) = ID_EX_MemRead & (ID_EX_RegisterRt!=0) & ((ID_EX_RegisterRt==IF_ID_RegisterRs) | (IF_ID_UsesRt & ID_EX_RegisterRt==IF_ID_RegisterRt)).
  - A load into $zero never stalls.
- md_hazard (combinational) = (state==MD_BUSY) & (ID_MulDiv | ID_ReadsHiLo).
- stall = load_use | md_hazard. When stall=1: PCWrite=0, IF_ID_Write=0, stall_mux=0, in the same cycle (zero latency). Otherwise all three are 1.
- muldiv_start = (state==RUN) & ID_MulDiv & ~load_use.
  - A load-use hazard on operands suppresses the start; it is re-evaluated after the bubble.
- RUN -> MD_BUSY on muldiv_start, with cnt <= MULDIV_LAT.
- In MD_BUSY:
  - cnt decrements every cycle.
  - When cnt==1 at a rising edge, go to RUN and set cnt=0.
  - muldiv_busy = (state==MD_BUSY), so it is high for exactly MULDIV_LAT cycles starting the cycle after the start pulse.
- A back-to-back mult/div or mfhi/mflo in ID during MD_BUSY stalls until state returns to RUN.
  - A second mult/div then starts in the first RUN cycle.
- Independent instructions flow through unstalled during MD_BUSY.
- IF_ID_Flush = branch_taken & ~stall.
  - If the branch is stalled, flush is withheld and the branch is re-resolved on the next cycle.
  - Flush never coincides with IF_ID_Write=0.
- stall_cycles increments on each rising edge where PCWrite=0, and saturates at all-ones.

Test Plan:
- Load-use hazard: lw $5 in EX (MemRead=1, Rt=5) with ID Rs=5 -> exactly one cycle of PCWrite=0, IF_ID_Write=0, stall_mux=0. Next cycle (MemRead=0) all outputs return to 1. stall_cycles=1.
- $zero and unused rt: MemRead=1, Rt=0, Rs=0 -> no stall. MemRead=1, Rt=7, IF_ID_RegisterRt=7, UsesRt=0 -> no stall.
- mult then mfhi (MULDIV_LAT=8): ID_MulDiv=1 at cycle T -> muldiv_start=1 at T only. muldiv_busy=1 for T+1..T+8. mfhi in ID from T+1 -> stall T+1..T+8, released at T+9. stall_cycles=8.
- mult then independent add: no stall during MD_BUSY, muldiv_busy still runs the full 8 cycles.
- Branch while stalled: branch_taken=1 together with load_use=1 -> IF_ID_Flush=0. Next cycle branch_taken=1 with no stall -> IF_ID_Flush=1, PCWrite=1.
- Reset and saturation: assert rst_n=0 at T+3 of MD_BUSY -> muldiv_busy=0 and state RUN immediately, stall_cycles=0. With PERF_W=4 and 20 stalled cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//
// Central stall/flush sequencer for a 5-stage MIPS pipeline. It combines the
// load-use hazard check with scheduling for the multi-cycle mult/div unit and
// taken-branch flushes of IF/ID. It also keeps a saturating count of stalled
// cycles for performance monitoring.
//
// Ports:
//   clk, rst_n            pipeline clock (rising edge), async active-low reset
//   ID_EX_MemRead         instruction in EX is a load
//   ID_EX_RegisterRt      destination register of that load
//   IF_ID_RegisterRs/Rt   source registers of the instruction in ID
//   IF_ID_UsesRt          instruction in ID reads rt
//   ID_MulDiv             instruction in ID is mult/multu/div/divu
//   ID_ReadsHiLo          instruction in ID is mfhi/mflo
//   branch_taken          branch resolved taken in ID this cycle
//   PCWrite               1 = PC updates
//   IF_ID_Write           1 = IF/ID register loads
//   stall_mux             0 = inject bubble into ID/EX
//   IF_ID_Flush           1 = clear IF/ID on next edge
//   muldiv_start          one-cycle start pulse to the mult/div unit
//   muldiv_busy           mult/div unit is busy
//   stall_cycles          saturating count of cycles with PCWrite=0
module pipeline_stall_controller #(
  parameter int unsigned MULDIV_LAT = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic              IF_ID_UsesRt,
  input  logic              ID_MulDiv,
  input  logic              ID_ReadsHiLo,
  input  logic              branch_taken,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              stall_mux,
  output logic              IF_ID_Flush,
  output logic              muldiv_start,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] LatCnt = CNT_W'(MULDIV_LAT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic md_hazard;
  logic stall;
  logic start;

  // Hazard detection. A load into $zero never creates a dependency.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
               ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
    md_hazard = (state_q == StMdBusy) && (ID_MulDiv || ID_ReadsHiLo);
    stall     = load_use || md_hazard;
    // A load-use hazard on the operands holds off the start until after the bubble.
    start     = (state_q == StRun) && ID_MulDiv && !load_use;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;

    unique case (state_q)
      StRun: begin
        if (start) begin
          state_d = StMdBusy;
          cnt_d   = LatCnt;
        end
      end
      StMdBusy: begin
        if (cnt_q == OneCnt) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - OneCnt;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase

    // Saturate rather than wrap so long runs still read as "many stalls".
    if (stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // Outputs. Everything is forced to the pass-through values while in reset,
  // independent of what the hazard inputs are doing.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    stall_mux    = 1'b1;
    IF_ID_Flush  = 1'b0;
    muldiv_start = 1'b0;
    muldiv_busy  = 1'b0;
    if (rst_n) begin
      PCWrite      = !stall;
      IF_ID_Write  = !stall;
      stall_mux    = !stall;
      // A stalled branch is re-resolved next cycle, so flush is withheld.
      IF_ID_Flush  = branch_taken && !stall;
      muldiv_start = start;
      muldiv_busy  = (state_q == StMdBusy);
    end
    stall_cycles = stall_cycles_q;
  end

endmodule
